// File: rtl/decoder.sv
// -----------------------------------------------------------------------------
// decoder -- system bus address decoder
//
// Purpose:
//   Samples the bus address every clock and decodes its upper four bits (the
//   region tag) into one of three registered slave selects. A 2-bit read-mux
//   select (SELR) follows one cycle behind the selects, so it lines up with
//   the slave read data that returns after the select has been seen.
//
// Parameters:
//   ADDR_WIDTH  bus address width (minimum 4)
//   S1_BASE     region tag for slave 1 (highest priority)
//   S2_BASE     region tag for slave 2
//   S3_BASE     region tag for slave 3 (lowest priority)
//
// Ports:
//   clk         bus clock, rising edge
//   rst_n       asynchronous active-low reset
//   addr        bus address; only addr[ADDR_WIDTH-1 -: 4] matters
//   slave1_sel  slave 1 select (1 cycle after addr)
//   slave2_sel  slave 2 select (1 cycle after addr)
//   slave3_sel  slave 3 select (1 cycle after addr)
//   SELR        read-mux select, 00 none / 01 s1 / 10 s2 / 11 s3 (2 cycles)
//   addr_err    unmapped-address flag, 1 cycle after addr
//               (only present when DECODER_ERR_EN is defined)
//
// Build option:
//   DECODER_ERR_EN  adds the addr_err output and its stage-1 register.
// -----------------------------------------------------------------------------
module decoder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [3:0]  S1_BASE    = 4'h0,
  parameter logic [3:0]  S2_BASE    = 4'h1,
  parameter logic [3:0]  S3_BASE    = 4'h2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  slave1_sel,
  output logic                  slave2_sel,
  output logic                  slave3_sel,
  output logic [1:0]            SELR
`ifdef DECODER_ERR_EN
  ,
  output logic                  addr_err
`endif
);

  logic [3:0] tag;
  assign tag = addr[ADDR_WIDTH-1 -: 4];

  // Offset bits are deliberately ignored by the decode.
  generate
    if (ADDR_WIDTH > 4) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^addr[ADDR_WIDTH-5:0];
    end
  endgenerate

  // Stage 1: one-hot selects {s3,s2,s1} and their encoded form.
  logic [2:0] sel_d,  sel_q;
  logic [1:0] code_d, code_q;
  // Stage 2: read-mux select.
  logic [1:0] selr_q;

  // Priority chain: an equal base for a lower-numbered slave wins, so the
  // selects stay one-hot even with duplicate bases. A tag carrying X/Z never
  // compares true and falls through to the unmapped default.
  always_comb begin
    sel_d  = 3'b000;
    code_d = 2'b00;
    if (tag == S1_BASE) begin
      sel_d  = 3'b001;
      code_d = 2'b01;
    end else if (tag == S2_BASE) begin
      sel_d  = 3'b010;
      code_d = 2'b10;
    end else if (tag == S3_BASE) begin
      sel_d  = 3'b100;
      code_d = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 3'b000;
      code_q <= 2'b00;
      selr_q <= 2'b00;
    end else begin
      sel_q  <= sel_d;
      code_q <= code_d;
      selr_q <= code_q;
    end
  end

  assign slave1_sel = sel_q[0];
  assign slave2_sel = sel_q[1];
  assign slave3_sel = sel_q[2];
  assign SELR       = selr_q;

`ifdef DECODER_ERR_EN
  logic err_d, err_q;

  // Unmapped exactly when no select was produced by the decode.
  assign err_d = (sel_d == 3'b000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign addr_err = err_q;
`endif

endmodule

// File: tb/tb_decoder.sv
// -----------------------------------------------------------------------------
// tb_decoder -- self-checking bench for decoder
//
// Three instances share clock and reset:
//   dut_a  default parameters (16-bit, bases 0/1/2)
//   dut_b  ADDR_WIDTH=20, default bases
//   dut_c  16-bit with S1_BASE=S2_BASE=8 (duplicate bases)
// A reference model maps each sampled address to a region number and keeps a
// history of regions per clock edge; selects come from the newest entry and
// SELR from the one before it.
// -----------------------------------------------------------------------------
module tb_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr_a = 16'h1234;
  logic [19:0] addr_b = 20'h01234;
  logic [15:0] addr_c = 16'h1234;

  logic s1_a, s2_a, s3_a, s1_b, s2_b, s3_b, s1_c, s2_c, s3_c;
  logic [1:0] selr_a, selr_b, selr_c;
`ifdef DECODER_ERR_EN
  logic err_a, err_b, err_c;
`endif

  always #5 clk = ~clk;

  decoder dut_a (
    .clk(clk), .rst_n(rst_n), .addr(addr_a),
    .slave1_sel(s1_a), .slave2_sel(s2_a), .slave3_sel(s3_a), .SELR(selr_a)
`ifdef DECODER_ERR_EN
    , .addr_err(err_a)
`endif
  );

  decoder #(.ADDR_WIDTH(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(addr_b),
    .slave1_sel(s1_b), .slave2_sel(s2_b), .slave3_sel(s3_b), .SELR(selr_b)
`ifdef DECODER_ERR_EN
    , .addr_err(err_b)
`endif
  );

  decoder #(.S1_BASE(4'h8), .S2_BASE(4'h8)) dut_c (
    .clk(clk), .rst_n(rst_n), .addr(addr_c),
    .slave1_sel(s1_c), .slave2_sel(s2_c), .slave3_sel(s3_c), .SELR(selr_c)
`ifdef DECODER_ERR_EN
    , .addr_err(err_c)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Region history per instance, newest first (0 = unmapped / reset).
  int hist_a[$];
  int hist_b[$];
  int hist_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // First matching base wins; no match means unmapped.
  function automatic int region(input int tag_v, input int b1, input int b2, input int b3);
    if (tag_v == b1) return 1;
    if (tag_v == b2) return 2;
    if (tag_v == b3) return 3;
    return 0;
  endfunction

  function automatic int newest(input int q[$]);
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  function automatic int older(input int q[$]);
    return (q.size() > 1) ? q[1] : 0;
  endfunction

  function automatic logic [2:0] onehot(input int r);
    return (r == 0) ? 3'b000 : 3'(1 << (r - 1));
  endfunction

  task automatic clear_model();
    hist_a = {};
    hist_b = {};
    hist_c = {};
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, " sel_a"},  {29'd0, s3_a, s2_a, s1_a}, {29'd0, onehot(newest(hist_a))});
    check({ctx, " selr_a"}, {30'd0, selr_a},           older(hist_a));
    check({ctx, " sel_b"},  {29'd0, s3_b, s2_b, s1_b}, {29'd0, onehot(newest(hist_b))});
    check({ctx, " selr_b"}, {30'd0, selr_b},           older(hist_b));
    check({ctx, " sel_c"},  {29'd0, s3_c, s2_c, s1_c}, {29'd0, onehot(newest(hist_c))});
    check({ctx, " selr_c"}, {30'd0, selr_c},           older(hist_c));
`ifdef DECODER_ERR_EN
    check({ctx, " err_a"}, {31'd0, err_a}, (hist_a.size() > 0 && hist_a[0] == 0) ? 1 : 0);
    check({ctx, " err_b"}, {31'd0, err_b}, (hist_b.size() > 0 && hist_b[0] == 0) ? 1 : 0);
    check({ctx, " err_c"}, {31'd0, err_c}, (hist_c.size() > 0 && hist_c[0] == 0) ? 1 : 0);
`endif
  endtask

  // One bus cycle: drive at the falling edge, update the model at the rising
  // edge, compare 1 time unit later.
  task automatic cycle(input logic rst_v, input logic [15:0] a, input logic [19:0] b,
                       input logic [15:0] c, input string ctx);
    @(negedge clk);
    rst_n  = rst_v;
    addr_a = a;
    addr_b = b;
    addr_c = c;
    @(posedge clk);
    if (rst_n) begin
      hist_a.push_front(region(int'(a) >> 12, 0, 1, 2));
      hist_b.push_front(region(int'(b) >> 16, 0, 1, 2));
      hist_c.push_front(region(int'(c) >> 12, 8, 8, 2));
      if (hist_a.size() > 4) void'(hist_a.pop_back());
      if (hist_b.size() > 4) void'(hist_b.pop_back());
      if (hist_c.size() > 4) void'(hist_c.pop_back());
    end else begin
      clear_model();
    end
    #1;
    check_outputs(ctx);
    $display("cycle %s rst_n=%0b a=%h b=%h c=%h sel_a=%b%b%b selr_a=%b",
             ctx, rst_n, a, b, c, s3_a, s2_a, s1_a, selr_a);
  endtask

  // Drop reset between edges and confirm everything clears without a clock.
  task automatic async_reset(input string ctx);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs(ctx);
    $display("async reset %s", ctx);
  endtask

  function automatic logic [3:0] rand_tag(input int focus);
    if ($urandom_range(0, 3) != 0) return 4'(focus + $urandom_range(0, 2));
    return 4'($urandom_range(0, 15));
  endfunction

  logic [15:0] seq_a [4] = '{16'h0000, 16'h0001, 16'h1002, 16'h2003};
  logic [15:0] off_a [5] = '{16'h0FFF, 16'h1FFF, 16'h2FFF, 16'h3000, 16'hF000};

  initial begin
    // Outputs must already be clear before any clock edge.
    #1;
    clear_model();
    check_outputs("reset_t0");

    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h1234, 20'h01234, 16'h1234, "reset_hold");

    // Release coincident with an address change: first edge samples it.
    cycle(1'b1, seq_a[0], 20'h00000, 16'h8000, "release");
    for (int i = 1; i < 4; i++) cycle(1'b1, seq_a[i], 20'h10000, 16'h2000, "seq");
    cycle(1'b1, 16'h0000, 20'h20000, 16'h1000, "seq_tail");

    for (int i = 0; i < 5; i++)
      cycle(1'b1, off_a[i], {off_a[i][15:12], 4'hF, off_a[i][11:0]}, off_a[i] | 16'h8000, "offset");
    cycle(1'b1, 16'h3000, 20'h30000, 16'h3000, "unmapped");
    cycle(1'b1, 16'hF000, 20'hFFFFF, 16'h1000, "unmapped");

    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i % 2 == 0) ? 16'h0000 : 16'h2000, (i % 2 == 0) ? 20'h00000 : 20'h20000,
            (i % 2 == 0) ? 16'h8000 : 16'h2000, "toggle");

    async_reset("async_mid");
    cycle(1'b0, 16'h0000, 20'h00000, 16'h8000, "held_low");
    cycle(1'b1, 16'h1000, 20'h10000, 16'h8ABC, "release2");
    cycle(1'b1, 16'h2000, 20'h2FFFF, 16'h0000, "after_rel");

    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        async_reset("async_rand");
        cycle(1'b0, 16'($urandom), 20'($urandom), 16'($urandom), "rand_rst");
      end
      cycle(1'b1,
            {rand_tag(0), 12'($urandom)},
            {rand_tag(0), 16'($urandom)},
            {rand_tag(7), 12'($urandom)},
            "rand");
      if ($countones({s1_a, s2_a, s3_a}) > 1) check("onehot_a", {29'd0, s3_a, s2_a, s1_a}, 32'd0);
      if ($countones({s1_c, s2_c, s3_c}) > 1) check("onehot_c", {29'd0, s3_c, s2_c, s1_c}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
